// File: rtl/mem_wb_stage.sv
// mem_wb_stage: RV32I writeback stage.
// Takes one retiring instruction per valid/ready handshake from MEM, picks the
// writeback source (ALU, aligned load data, PC+4) and drives the register-file
// write port from flops only, because the register file samples on the falling
// edge and must never see a decode glitch.
// Optional feature macro: WB_INSTRET_EN (adds the retired-instruction counter
// on instret_o; when undefined instret_o is tied to zero).

module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [4:0]       in_rd_i,
    input  logic             in_wen_i,
    input  logic [1:0]       in_wbsel_i,
    input  logic [XLEN-1:0]  in_alu_i,
    input  logic [XLEN-1:0]  in_pc4_i,
    input  logic [2:0]       in_funct3_i,
    input  logic [1:0]       in_addr_lo_i,
    input  logic             dmem_rvalid_i,
    input  logic [XLEN-1:0]  dmem_rdata_i,
    output logic [4:0]       rsW_o,
    output logic [XLEN-1:0]  dataW_o,
    output logic             regWEn_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] instret_o
);

    // state       | meaning
    // ------------+-----------------------------------------------------------
    // ST_IDLE     | empty, ready to accept
    // ST_WAIT_MEM | holding a load, waiting for dmem_rvalid_i; busy_o high
    // ST_WRITE    | one-cycle register-file write; may accept the next entry

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } state_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t state;
    state_t state_nxt;

    logic            accept;
    logic            in_needs_mem;

    // Load context kept across WAIT_MEM
    logic [4:0]      rd_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;

    logic [4:0]      rsw_nxt;
    logic [XLEN-1:0] dataw_nxt;
    logic            regwen_nxt;
    logic            busy_nxt;
    logic [XLEN-1:0] load_data;

    // Extract and extend the addressed byte/halfword from the raw load word.
    function automatic logic [XLEN-1:0] load_align(
        input logic [2:0]      f3,
        input logic [1:0]      a,
        input logic [XLEN-1:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_LB:   load_align = {{(XLEN-8){b[7]}}, b};
            F3_LBU:  load_align = {{(XLEN-8){1'b0}}, b};
            F3_LH:   load_align = {{(XLEN-16){h[15]}}, h};
            F3_LHU:  load_align = {{(XLEN-16){1'b0}}, h};
            default: load_align = w;
        endcase
    endfunction

    // Ready depends on state alone so MEM never sees a path from its own valid.
    assign in_ready_o   = (state == ST_IDLE) || (state == ST_WRITE);
    assign accept       = in_valid_i && in_ready_o;
    assign in_needs_mem = (in_wbsel_i == WB_MEM) && in_wen_i;
    assign load_data    = load_align(funct3_q, addr_lo_q, dmem_rdata_i);

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_WRITE: begin
                if (accept) begin
                    state_nxt = in_needs_mem ? ST_WAIT_MEM : ST_WRITE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                if (dmem_rvalid_i) begin
                    state_nxt = ST_WRITE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the write-port flops, computed for the
    // cycle being entered so that WRITE sees them straight from registers.
    always_comb begin
        rsw_nxt    = rsW_o;
        dataw_nxt  = dataW_o;
        regwen_nxt = 1'b0;
        busy_nxt   = (state_nxt == ST_WAIT_MEM);
        if (state == ST_WAIT_MEM) begin
            if (dmem_rvalid_i) begin
                rsw_nxt    = rd_q;
                dataw_nxt  = load_data;
                regwen_nxt = (rd_q != 5'd0);
            end
        end else if (accept && !in_needs_mem) begin
            rsw_nxt    = in_rd_i;
            dataw_nxt  = (in_wbsel_i == WB_PC4) ? in_pc4_i : in_alu_i;
            regwen_nxt = in_wen_i && (in_rd_i != 5'd0);
        end
    end

    // Write-port and busy flops.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            rsW_o    <= 5'd0;
            dataW_o  <= '0;
            regWEn_o <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            rsW_o    <= rsw_nxt;
            dataW_o  <= dataw_nxt;
            regWEn_o <= regwen_nxt;
            busy_o   <= busy_nxt;
        end
    end

    // Capture load context on every accept.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            rd_q      <= 5'd0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
        end else if (accept) begin
            rd_q      <= in_rd_i;
            funct3_q  <= in_funct3_i;
            addr_lo_q <= in_addr_lo_i;
        end
    end

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] instret_q;

    // Count every WRITE cycle, wrapping naturally.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            instret_q <= '0;
        end else if (state == ST_WRITE) begin
            instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

    // WB_ALU is the default source; named here so the encoding table is complete.
    logic unused_wbsel_alu;
    assign unused_wbsel_alu = (WB_ALU == 2'b00);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage: each scenario task drives stimulus and
// compares outputs against hand-computed values one step after the rising edge.

module tb_mem_wb_stage;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [4:0]  in_rd_i = 5'd0;
    logic        in_wen_i = 1'b0;
    logic [1:0]  in_wbsel_i = 2'b00;
    logic [31:0] in_alu_i = 32'd0;
    logic [31:0] in_pc4_i = 32'd0;
    logic [2:0]  in_funct3_i = 3'd0;
    logic [1:0]  in_addr_lo_i = 2'd0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = 32'd0;
    logic [4:0]  rsW_o;
    logic [31:0] dataW_o;
    logic        regWEn_o;
    logic        busy_o;
    logic [63:0] instret_o;

    int checks = 0;
    int failures = 0;

    mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_rd_i      (in_rd_i),
        .in_wen_i     (in_wen_i),
        .in_wbsel_i   (in_wbsel_i),
        .in_alu_i     (in_alu_i),
        .in_pc4_i     (in_pc4_i),
        .in_funct3_i  (in_funct3_i),
        .in_addr_lo_i (in_addr_lo_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i),
        .rsW_o        (rsW_o),
        .dataW_o      (dataW_o),
        .regWEn_o     (regWEn_o),
        .busy_o       (busy_o),
        .instret_o    (instret_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [4:0] rd, input logic wen, input logic [1:0] wbsel,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [2:0] f3, input logic [1:0] alo);
        in_valid_i   = 1'b1;
        in_rd_i      = rd;
        in_wen_i     = wen;
        in_wbsel_i   = wbsel;
        in_alu_i     = alu;
        in_pc4_i     = pc4;
        in_funct3_i  = f3;
        in_addr_lo_i = alo;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) cyc;
        checks++; if (regWEn_o !== 1'b0) begin failures++; $display("FAIL reset_regwen got=%b exp=0", regWEn_o); end
        checks++; if (rsW_o !== 5'd0) begin failures++; $display("FAIL reset_rsw got=%0d exp=0", rsW_o); end
        checks++; if (dataW_o !== 32'd0) begin failures++; $display("FAIL reset_dataw got=%h exp=0", dataW_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (instret_o !== 64'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret_o); end
        reset = 1'b0;
        cyc;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
    endtask

    task automatic test_instret;
        logic [63:0] exp;
        for (int i = 0; i < 7; i++) begin
            drive(5'd3, 1'b1, 2'b00, 32'h10 + i, 32'd0, 3'd0, 2'd0);
            cyc;
        end
        in_valid_i = 1'b0;
        cyc;
`ifdef WB_INSTRET_EN
        exp = 64'd7;
`else
        exp = 64'd0;
`endif
        checks++; if (instret_o !== exp) begin failures++; $display("FAIL instret got=%0d exp=%0d", instret_o, exp); end
    endtask

    task automatic test_alu;
        drive(5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 3'd0, 2'd0);
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL alu_ready got=%b exp=1", in_ready_o); end
        cyc;
        in_valid_i = 1'b0;
        checks++; if (regWEn_o !== 1'b1) begin failures++; $display("FAIL alu_regwen got=%b exp=1", regWEn_o); end
        checks++; if (rsW_o !== 5'd5) begin failures++; $display("FAIL alu_rsw got=%0d exp=5", rsW_o); end
        checks++; if (dataW_o !== 32'h1234_5678) begin failures++; $display("FAIL alu_dataw got=%h exp=12345678", dataW_o); end
        cyc;
        checks++; if (regWEn_o !== 1'b0) begin failures++; $display("FAIL alu_regwen_drop got=%b exp=0", regWEn_o); end
        checks++; if (dataW_o !== 32'h1234_5678) begin failures++; $display("FAIL alu_dataw_hold got=%h exp=12345678", dataW_o); end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [1:0] alo,
                             input logic [31:0] rdata, input logic [31:0] exp);
        drive(5'd7, 1'b1, 2'b01, 32'hDEAD_BEEF, 32'h0, f3, alo);
        cyc;
        in_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (busy_o !== 1'b1 || regWEn_o !== 1'b0 || in_ready_o !== 1'b0) begin
                failures++; $display("FAIL %s_wait busy=%b regwen=%b ready=%b exp=1/0/0", name, busy_o, regWEn_o, in_ready_o);
            end
            cyc;
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        cyc;
        dmem_rvalid_i = 1'b0;
        checks++; if (regWEn_o !== 1'b1 || rsW_o !== 5'd7 || busy_o !== 1'b0) begin
            failures++; $display("FAIL %s_write regwen=%b rsw=%0d busy=%b exp=1/7/0", name, regWEn_o, rsW_o, busy_o);
        end
        checks++; if (dataW_o !== exp) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, dataW_o, exp); end
        cyc;
        checks++; if (regWEn_o !== 1'b0) begin failures++; $display("FAIL %s_drop got=%b exp=0", name, regWEn_o); end
    endtask

    task automatic test_back_to_back;
        drive(5'd1, 1'b1, 2'b00, 32'h100, 32'h0, 3'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready_o); end
            cyc;
            if (i < 3) drive(5'(i + 2), 1'b1, 2'b00, 32'h100 + 32'(i + 1), 32'h0, 3'd0, 2'd0);
            else in_valid_i = 1'b0;
            checks++; if (regWEn_o !== 1'b1 || rsW_o !== 5'(i + 1) || dataW_o !== 32'h100 + 32'(i)) begin
                failures++; $display("FAIL b2b_write%0d regwen=%b rsw=%0d data=%h exp=1/%0d/%h", i, regWEn_o, rsW_o, dataW_o, i + 1, 32'h100 + 32'(i));
            end
        end
        cyc;
        checks++; if (regWEn_o !== 1'b0) begin failures++; $display("FAIL b2b_drop got=%b exp=0", regWEn_o); end
    endtask

    task automatic test_jal;
        drive(5'd1, 1'b1, 2'b10, 32'hDEAD, 32'h104, 3'd0, 2'd0);
        cyc;
        drive(5'd2, 1'b1, 2'b11, 32'hCAFE, 32'h200, 3'd0, 2'd0);
        checks++; if (dataW_o !== 32'h104 || regWEn_o !== 1'b1) begin
            failures++; $display("FAIL jal_pc4 data=%h regwen=%b exp=00000104/1", dataW_o, regWEn_o);
        end
        cyc;
        drive(5'd9, 1'b1, 2'b10, 32'h5, 32'h104, 3'd0, 2'd0);
        checks++; if (dataW_o !== 32'hCAFE || rsW_o !== 5'd2) begin
            failures++; $display("FAIL wbsel11_alu data=%h rsw=%0d exp=0000cafe/2", dataW_o, rsW_o);
        end
        cyc;
        in_valid_i = 1'b0;
        cyc;
    endtask

    task automatic test_rvalid_idle;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        cyc;
        cyc;
        dmem_rvalid_i = 1'b0;
        checks++; if (regWEn_o !== 1'b0 || busy_o !== 1'b0 || dataW_o !== 32'h104) begin
            failures++; $display("FAIL rvalid_idle regwen=%b busy=%b data=%h exp=0/0/00000104", regWEn_o, busy_o, dataW_o);
        end
    endtask

    task automatic test_rd0;
        drive(5'd0, 1'b1, 2'b00, 32'h77, 32'h0, 3'd0, 2'd0);
        cyc;
        in_valid_i = 1'b0;
        checks++; if (regWEn_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL rd0_alu regwen=%b busy=%b exp=0/0", regWEn_o, busy_o);
        end
        cyc;
        drive(5'd0, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0);
        cyc;
        in_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rd0_load_wait got=%b exp=1", busy_o); end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1111_2222;
        cyc;
        dmem_rvalid_i = 1'b0;
        checks++; if (regWEn_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++; $display("FAIL rd0_load_write regwen=%b busy=%b ready=%b exp=0/0/1", regWEn_o, busy_o, in_ready_o);
        end
        cyc;
        drive(5'd6, 1'b0, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0);
        cyc;
        in_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || regWEn_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++; $display("FAIL load_wen0 busy=%b regwen=%b ready=%b exp=0/0/1", busy_o, regWEn_o, in_ready_o);
        end
        cyc;
    endtask

    task automatic test_reset_wait;
        drive(5'd8, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0);
        cyc;
        in_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rstwait_busy got=%b exp=1", busy_o); end
        reset = 1'b1;
        cyc;
        reset = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hABCD_EF01;
        cyc;
        dmem_rvalid_i = 1'b0;
        checks++; if (regWEn_o !== 1'b0 || rsW_o !== 5'd0 || dataW_o !== 32'd0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++; $display("FAIL rstwait_out regwen=%b rsw=%0d data=%h busy=%b ready=%b exp=0/0/0/0/1", regWEn_o, rsW_o, dataW_o, busy_o, in_ready_o);
        end
        cyc;
        checks++; if (regWEn_o !== 1'b0 || dataW_o !== 32'd0) begin
            failures++; $display("FAIL rstwait_late regwen=%b data=%h exp=0/0", regWEn_o, dataW_o);
        end
    endtask

    initial begin
        test_reset;
        test_instret;
        test_alu;
        test_load("lb",   3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80);
        test_load("lbu",  3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080);
        test_load("lb3",  3'b000, 2'd3, 32'h7F00_0000, 32'h0000_007F);
        test_load("lh",   3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
        test_load("lhu",  3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001);
        test_load("lh1",  3'b001, 2'd1, 32'h0000_F00D, 32'hFFFF_F00D);
        test_load("lw",   3'b010, 2'd2, 32'h8001_0000, 32'h8001_0000);
        test_load("f011", 3'b011, 2'd1, 32'h1234_ABCD, 32'h1234_ABCD);
        test_back_to_back;
        test_jal;
        test_rvalid_idle;
        test_rd0;
        test_reset_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
